// File: rtl/ddr_ctrl_pkg.sv
// Shared types for the DDR controller and its request queue: the request
// record carried through the queue, the queue FSM states and the default
// user-side widths. A saturating increment helper serves the optional
// statistics counters of ddr_req_queue (DDR_REQ_QUEUE_STATS_EN).
package ddr_ctrl_pkg;

  localparam int DDR_ADDR_W = 11;  // bank, row, column
  localparam int DDR_DATA_W = 16;

  // One queued user request, as presented to top_DDR_controller.
  typedef struct packed {
    logic                  wr;     // 1 = write, 0 = read
    logic [DDR_ADDR_W-1:0] addr;
    logic [DDR_DATA_W-1:0] wdata;  // don't-care for reads
  } ddr_req_t;

  // Request queue issue FSM.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,  // waiting for a queued request and an idle controller
    ST_WAIT_ACK  = 2'd1,  // command presented, waiting for cmd_exec_ack
    ST_WAIT_DONE = 2'd2   // command accepted, waiting for the controller to go idle
  } req_q_state_e;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == STAT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/ddr_req_fifo.sv
// Synchronous FIFO of ddr_req_t. The head entry is always visible on `head`
// (first-word fall-through), so the consumer reads it and pops in the same
// cycle. Pointers wrap naturally because DEPTH is a power of two; occupancy
// is a separate 0..DEPTH counter, which keeps full/empty unambiguous.
module ddr_req_fifo
  import ddr_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  ddr_req_t                 push_data,
  input  logic                     pop,
  output ddr_req_t                 head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ddr_req_t           mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  // Guard against overflow/underflow so a misbehaving caller cannot corrupt
  // the occupancy count.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage write port.
  // NOTE: the storage array has no reset: an entry is only read after it has
  // been written, and leaving it out keeps the array in plain RAM/flops
  // without a reset tree.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;  // idle, or push and pop cancel out
      endcase
    end
  end

endmodule

// File: rtl/ddr_req_queue.sv
// Request buffer between the user port and top_DDR_controller. User requests
// are queued in ddr_req_fifo and issued one at a time through a three-state
// handshake (load, ack, done). Read data returned on valid_data is handed
// back to the user as a single-cycle rd_valid pulse; only the first
// valid_data of each read is taken.
// Optional build macro DDR_REQ_QUEUE_STATS_EN adds saturating counters of
// issued writes, issued reads and full cycles.
// ADDR_W/DATA_W must match the ddr_ctrl_pkg widths that size ddr_req_t.
module ddr_req_queue
  import ddr_ctrl_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = DDR_ADDR_W,
  parameter int DATA_W = DDR_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  // user request port
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wr,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  // user read return
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   q_level,
  // controller command port
  output logic                     WR_command,
  output logic [ADDR_W-1:0]        DRAM_Address,
  output logic [DATA_W-1:0]        Write_data,
  input  logic                     busy,
  input  logic                     cmd_exec_ack,
  input  logic                     valid_data,
  input  logic [DATA_W-1:0]        Read_data
`ifdef DDR_REQ_QUEUE_STATS_EN
  ,
  output logic [15:0]              stat_wr_cnt,
  output logic [15:0]              stat_rd_cnt,
  output logic [15:0]              stat_full_cyc
`else
  // statistics ports are not built
`endif
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  ddr_req_t            push_data;
  ddr_req_t            head;
  logic                push;
  logic                fifo_full;
  logic                fifo_empty;
  logic [LVL_W-1:0]    fifo_count;

  req_q_state_e        state_q;
  req_q_state_e        state_d;
  logic                load;       // issue the FIFO head this cycle
  logic                capture;    // take Read_data this cycle
  logic                is_rd_q;    // command in flight is a read
  logic                rd_taken_q; // its read data has already been taken

  // req_ready depends only on registered occupancy and the reset pin, so
  // there is no path from req_valid back to req_ready.
  assign req_ready = reset && !fifo_full;
  assign push      = req_valid && req_ready;
  assign q_level   = fifo_count;
  assign push_data = '{wr: req_wr, addr: req_addr, wdata: req_wdata};

  ddr_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (load),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and issue/capture decisions.
  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // cmd_exec_ack is deliberately ignored here.
        if (!fifo_empty && !busy) begin
          load    = 1'b1;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (cmd_exec_ack) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // valid_data during a write, or a repeat during a read, is dropped.
        if (is_rd_q && valid_data && !rd_taken_q) begin
          capture = 1'b1;
        end
        if (!busy && !cmd_exec_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller command registers: loaded on issue, held otherwise, so they
  // keep the last command's values while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      WR_command   <= 1'b0;
      DRAM_Address <= '0;
      Write_data   <= '0;
      is_rd_q      <= 1'b0;
    end else if (load) begin
      WR_command   <= head.wr;
      DRAM_Address <= head.addr;
      Write_data   <= head.wdata;
      is_rd_q      <= !head.wr;
    end
  end

  // Read return: register Read_data and pulse rd_valid for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_taken_q <= 1'b0;
    end else begin
      rd_valid <= capture;
      if (capture) begin
        rd_data    <= Read_data;
        rd_taken_q <= 1'b1;
      end else if (load) begin
        rd_taken_q <= 1'b0;
      end
    end
  end

`ifdef DDR_REQ_QUEUE_STATS_EN
  // Saturating issue and full-cycle counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_wr_cnt   <= '0;
      stat_rd_cnt   <= '0;
      stat_full_cyc <= '0;
    end else begin
      if (load && head.wr)  stat_wr_cnt <= sat_inc(stat_wr_cnt);
      if (load && !head.wr) stat_rd_cnt <= sat_inc(stat_rd_cnt);
      if (fifo_full)        stat_full_cyc <= sat_inc(stat_full_cyc);
    end
  end
`else
  // statistics counters are not built
`endif

endmodule

// File: tb/tb_ddr_req_queue.sv
// Self-checking bench for ddr_req_queue. The bench plays the controller and
// the user; a queue of pushed requests is the reference, and every cycle the
// occupancy, ready, command outputs and read return are compared with it.
module tb_ddr_req_queue;
  import ddr_ctrl_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [LVL_W-1:0]  q_level;
  logic              WR_command;
  logic [ADDR_W-1:0] DRAM_Address;
  logic [DATA_W-1:0] Write_data;
  logic              busy;
  logic              cmd_exec_ack;
  logic              valid_data;
  logic [DATA_W-1:0] Read_data;
`ifdef DDR_REQ_QUEUE_STATS_EN
  logic [15:0]       stat_wr_cnt;
  logic [15:0]       stat_rd_cnt;
  logic [15:0]       stat_full_cyc;
`endif

  always #5 clk = ~clk;

  ddr_req_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .q_level      (q_level),
    .WR_command   (WR_command),
    .DRAM_Address (DRAM_Address),
    .Write_data   (Write_data),
    .busy         (busy),
    .cmd_exec_ack (cmd_exec_ack),
    .valid_data   (valid_data),
    .Read_data    (Read_data)
`ifdef DDR_REQ_QUEUE_STATS_EN
    ,
    .stat_wr_cnt   (stat_wr_cnt),
    .stat_rd_cnt   (stat_rd_cnt),
    .stat_full_cyc (stat_full_cyc)
`endif
  );

  // Reference state
  int          n_checks = 0;
  int          n_fail   = 0;
  ddr_req_t    mq[$];        // accepted, not yet issued, in push order
  ddr_req_t    last_cmd;     // last command handed to the controller
  logic        exp_rdv;      // rd_valid expected after the coming edge
  logic [15:0] exp_rd_data;  // last read data handed back
  int          m_wr, m_rd, m_full;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic ddr_req_t rand_req();
    ddr_req_t r;
    r.wr    = 1'($urandom_range(0, 1));
    r.addr  = ADDR_W'($urandom);
    r.wdata = DATA_W'($urandom);
    return r;
  endfunction

  task automatic check_cmd(input string tag);
    check({tag, ".WR_command"},   32'(WR_command),   32'(last_cmd.wr));
    check({tag, ".DRAM_Address"}, 32'(DRAM_Address), 32'(last_cmd.addr));
    check({tag, ".Write_data"},   32'(Write_data),   32'(last_cmd.wdata));
  endtask

  // One clock cycle, entered and left at the falling edge.
  // push_mode: 0 none, 1 random coin-flip, 2 push preq.
  // pop_now: the queue is idle with busy low and has entries, so the head
  // is issued at this edge.
  task automatic cycle(input int push_mode, input ddr_req_t preq, input bit pop_now);
    ddr_req_t r;
    bit       can_push;
    bit       pushed;
    r         = (push_mode == 2) ? preq : rand_req();
    req_valid = (push_mode == 2) || (push_mode == 1 && $urandom_range(0, 1) == 1);
    req_wr    = r.wr;
    req_addr  = r.addr;
    req_wdata = r.wdata;
    can_push  = (mq.size() < DEPTH);
    #1;
    check("req_ready", 32'(req_ready), 32'(can_push));
    pushed = req_valid && can_push;
    if (mq.size() == DEPTH) m_full++;
    @(posedge clk);
    if (pop_now) begin
      last_cmd = mq.pop_front();
      if (last_cmd.wr) m_wr++;
      else             m_rd++;
    end
    if (pushed) mq.push_back(r);
    @(negedge clk);
    req_valid = 1'b0;
    check("q_level",  32'(q_level),  32'(mq.size()));
    check_cmd("cmd");
    check("rd_valid", 32'(rd_valid), 32'(exp_rdv));
    check("rd_data",  32'(rd_data),  32'(exp_rd_data));
    exp_rdv = 1'b0;
  endtask

  // Full controller handshake for the head entry; queue must be idle.
  task automatic issue(input int load_pm, input ddr_req_t load_req, input int pm,
                       input int ack_dly, input logic [15:0] rdata);
    bit is_rd;
    busy         = 1'b0;
    cmd_exec_ack = 1'b0;
    valid_data   = 1'b0;
    is_rd        = !mq[0].wr;
    cycle(load_pm, load_req, 1'b1);          // issue edge
    busy = 1'b1;
    repeat (ack_dly) cycle(pm, '0, 1'b0);    // outputs held while waiting
    cmd_exec_ack = 1'b1;
    cycle(pm, '0, 1'b0);
    cmd_exec_ack = 1'b0;
    cycle(pm, '0, 1'b0);
    valid_data = 1'b1;
    Read_data  = rdata;
    if (is_rd) begin
      exp_rdv     = 1'b1;
      exp_rd_data = rdata;
    end
    cycle(pm, '0, 1'b0);
    Read_data = ~rdata;                      // second valid_data must be ignored
    cycle(pm, '0, 1'b0);
    valid_data = 1'b0;
    busy       = 1'b0;
    cycle(pm, '0, 1'b0);                     // back to idle
  endtask

  // A cycle with nothing to issue: stray ack/valid_data must be ignored.
  task automatic idle_cycle(input int pm);
    busy         = (mq.size() > 0) ? 1'b1 : 1'($urandom_range(0, 1));
    cmd_exec_ack = 1'($urandom_range(0, 1));
    valid_data   = 1'($urandom_range(0, 1));
    Read_data    = DATA_W'($urandom);
    cycle(pm, '0, 1'b0);
    cmd_exec_ack = 1'b0;
    valid_data   = 1'b0;
  endtask

  task automatic clear_model();
    mq.delete();
    last_cmd    = '0;
    exp_rdv     = 1'b0;
    exp_rd_data = '0;
    m_wr        = 0;
    m_rd        = 0;
    m_full      = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ddr_req_t r;
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_wr       = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    busy         = 1'b0;
    cmd_exec_ack = 1'b0;
    valid_data   = 1'b0;
    Read_data    = '0;
    clear_model();

    // Reset state
    #1;
    check("rst.req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.q_level",  32'(q_level),  32'd0);
    check("rst.rd_valid", 32'(rd_valid), 32'd0);
    check("rst.rd_data",  32'(rd_data),  32'd0);
    check_cmd("rst");
    reset = 1'b1;
    #1;
    check("rel.req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    // Single write: issued one cycle after the push
    r = '{wr: 1'b1, addr: 11'b01101011010, wdata: 16'hAAAA};
    cycle(2, r, 1'b0);
    issue(0, '0, 0, 1, 16'h0000);

    // Single read: ack after 2 cycles, data FE15 returned
    r = '{wr: 1'b0, addr: 11'b01101101111, wdata: 16'h0000};
    cycle(2, r, 1'b0);
    issue(0, '0, 0, 2, 16'hFE15);

    // Fill while busy: fifth push refused, then drain in order
    busy = 1'b1;
    repeat (DEPTH + 1) cycle(2, rand_req(), 1'b0);
    while (mq.size() > 0) issue(0, '0, 0, $urandom_range(0, 3), 16'($urandom));

    // Simultaneous push and pop at level 2
    busy = 1'b1;
    repeat (2) cycle(2, rand_req(), 1'b0);
    issue(2, rand_req(), 0, 0, 16'($urandom));
    while (mq.size() > 0) issue(0, '0, 0, 1, 16'($urandom));

    // Reset while a read waits for its data
    busy = 1'b0;
    r = '{wr: 1'b0, addr: 11'h2A5, wdata: 16'h0000};
    cycle(2, r, 1'b0);
    cycle(2, rand_req(), 1'b1);   // issue the read, queue another request
    busy         = 1'b1;
    cmd_exec_ack = 1'b1;
    cycle(0, '0, 1'b0);
    cmd_exec_ack = 1'b0;
    cycle(0, '0, 1'b0);           // in WAIT_DONE, no data yet
    reset = 1'b0;
    clear_model();
    #1;
    check("mrst.q_level",   32'(q_level),   32'd0);
    check("mrst.req_ready", 32'(req_ready), 32'd0);
    check("mrst.rd_valid",  32'(rd_valid),  32'd0);
    check("mrst.rd_data",   32'(rd_data),   32'd0);
    check_cmd("mrst");
    @(negedge clk);
    reset      = 1'b1;
    valid_data = 1'b1;
    Read_data  = 16'h1234;
    cycle(0, '0, 1'b0);           // late valid_data must not produce rd_valid
    valid_data = 1'b0;
    busy       = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      if (mq.size() > 0 && $urandom_range(0, 2) != 0)
        issue(1, '0, 1, $urandom_range(0, 3), 16'($urandom));
      else
        idle_cycle(1);
    end
    while (mq.size() > 0) issue(0, '0, 0, 0, 16'($urandom));

`ifdef DDR_REQ_QUEUE_STATS_EN
    check("stat_wr_cnt",   32'(stat_wr_cnt),   32'(m_wr));
    check("stat_rd_cnt",   32'(stat_rd_cnt),   32'(m_rd));
    check("stat_full_cyc", 32'(stat_full_cyc), 32'(m_full));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
